// File: rtl/shader_spi_master.sv
// shader_spi_master: byte-oriented SPI mode-0 initiator.
// A valid/ready byte stream with a per-byte last flag frames each CS
// transaction; every byte sent returns one byte shifted in from spi_miso.
module shader_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_cs,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    NEXT,
    HOLD,
    GAP
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [DIV_W-1:0]  r_div,      w_div_nxt;
  logic [BIT_W-1:0]  r_bit,      w_bit_nxt;
  logic [DATA_W-1:0] r_tx,       w_tx_nxt;
  logic [DATA_W-1:0] r_rx,       w_rx_nxt;
  logic [DATA_W-1:0] r_rx_data,  w_rx_data_nxt;
  logic              r_last,     w_last_nxt;
  logic              r_cs,       w_cs_nxt;
  logic              r_sclk,     w_sclk_nxt;
  logic              r_mosi,     w_mosi_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_tx_ready, w_tx_ready_nxt;
  logic              r_busy,     w_busy_nxt;

  logic w_accept;
  logic w_div_done;

  assign w_accept   = tx_valid && r_tx_ready;
  assign w_div_done = (r_div == DIV_MAX);

  // Register all state and outputs; synchronous reset discards any partial byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_last     <= 1'b0;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_bit      <= w_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_last     <= w_last_nxt;
      r_cs       <= w_cs_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic; tx_ready/busy derive from the next state
  // so they stay registered yet line up with the state they describe.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_bit_nxt      = r_bit;
    w_tx_nxt       = r_tx;
    w_rx_nxt       = r_rx;
    w_rx_data_nxt  = r_rx_data;
    w_last_nxt     = r_last;
    w_cs_nxt       = r_cs;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_rx_valid_nxt = 1'b0;

    case (r_state)
      IDLE, NEXT: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = tx_data;
          w_mosi_nxt  = tx_data[DATA_W-1];
          w_last_nxt  = tx_last;
          w_cs_nxt    = 1'b0;
          w_sclk_nxt  = 1'b0;
        end
      end

      SHIFT: begin
        if (w_div_done) begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
            w_rx_nxt   = {r_rx[DATA_W-2:0], spi_miso};
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit == BIT_MAX) begin
              w_rx_data_nxt  = r_rx;
              w_rx_valid_nxt = 1'b1;
              w_state_nxt    = r_last ? HOLD : NEXT;
            end else begin
              w_bit_nxt  = r_bit + BIT_ONE;
              w_tx_nxt   = r_tx << 1;
              w_mosi_nxt = r_tx[DATA_W-2];
            end
          end
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end

      HOLD: begin
        if (w_div_done) begin
          w_div_nxt   = '0;
          w_cs_nxt    = 1'b1;
          w_state_nxt = GAP;
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end

      GAP: begin
        if (w_div_done) begin
          w_div_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cs_nxt    = 1'b1;
        w_sclk_nxt  = 1'b0;
      end
    endcase

    w_tx_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == NEXT);
    w_busy_nxt     = (w_state_nxt != IDLE);
  end

  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign spi_cs   = r_cs;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_shader_spi_master.sv
// Directed bench for shader_spi_master: a CLK_DIV=2 instance and a CLK_DIV=1
// instance share the stimulus; a mode-0 slave model watches the selected one.
module tb_shader_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sel;
  logic       tx_valid;
  logic       tx_last;
  logic [7:0] tx_data;
  logic       v0, v1;

  assign v0 = tx_valid & ~sel;
  assign v1 = tx_valid & sel;

  logic       rdy0, rxv0, busy0, cs0, sclk0, mosi0, miso0;
  logic [7:0] rxd0;
  logic       rdy1, rxv1, busy1, cs1, sclk1, mosi1, miso1;
  logic [7:0] rxd1;

  shader_spi_master #(.CLK_DIV(2), .DATA_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(v0), .tx_last(tx_last), .tx_ready(rdy0),
    .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
    .spi_cs(cs0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0)
  );

  shader_spi_master #(.CLK_DIV(1), .DATA_W(8)) u_dut1 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(v1), .tx_last(tx_last), .tx_ready(rdy1),
    .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1),
    .spi_cs(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // Selected-instance view
  logic       m_rdy, m_rxv, m_busy, m_cs, m_sclk, m_mosi;
  logic [7:0] m_rxd;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_rxv  = sel ? rxv1  : rxv0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_cs   = sel ? cs1   : cs0;
  assign m_sclk = sel ? sclk1 : sclk0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_rxd  = sel ? rxd1  : rxd0;

  // Mode-0 slave model: captures mosi on sclk rise, shifts its pattern on fall
  int          s_pulses = 0;
  int          s_falls  = 0;
  int          s_bad    = 0;
  logic [31:0] s_rx     = '0;
  logic        slv_mode;
  logic [7:0]  slv_pat;
  int          fall_base;
  logic        w_slv_bit;

  always @(posedge m_sclk) begin
    s_pulses++;
    s_rx = {s_rx[30:0], m_mosi};
    if (m_cs) s_bad++;
  end

  always @(negedge m_sclk) s_falls++;

  assign w_slv_bit = slv_pat[3'd7 - 3'(s_falls - fall_base)];
  assign miso0     = slv_mode ? w_slv_bit : mosi0;
  assign miso1     = mosi1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Burst driver / recorder state
  logic [7:0] bytes [4];
  int         nbytes;
  int         pause_lo;
  int         pause_until;
  int         acc_t [4];
  int         rxv_t [4];
  logic [7:0] rxv_d [4];
  int         n_acc, n_rxv, cs_rise_n, cs_rise_t, rdy_t, pause_bad;

  // Called at a negedge; k counts clock edges from the first accept edge (k=0).
  task automatic run_burst(input int maxcyc);
    logic acc;
    logic prev_cs;
    int   idx;
    n_acc = 0; n_rxv = 0; cs_rise_n = 0; cs_rise_t = -1; rdy_t = -1;
    pause_bad = 0; idx = 0;
    tx_data  = bytes[0];
    tx_last  = (nbytes == 1);
    tx_valid = 1'b1;
    acc      = m_rdy;
    prev_cs  = m_cs;
    for (int k = 0; k < maxcyc; k++) begin
      @(negedge clk);
      if (acc) begin
        if (n_acc < 4) acc_t[n_acc] = k;
        n_acc++;
        idx++;
      end
      if (m_rxv) begin
        if (n_rxv < 4) begin
          rxv_t[n_rxv] = k;
          rxv_d[n_rxv] = m_rxd;
        end
        n_rxv++;
      end
      if (!prev_cs && m_cs) begin
        if (cs_rise_n == 0) cs_rise_t = k;
        cs_rise_n++;
      end
      prev_cs = m_cs;
      if (cs_rise_n > 0 && rdy_t < 0 && m_rdy) rdy_t = k;
      if (k > pause_lo && k <= pause_until && (m_cs || m_sclk)) pause_bad++;
      if (idx < nbytes && idx < 4 && k >= pause_until) begin
        tx_data  = bytes[idx];
        tx_last  = (idx == nbytes - 1);
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
      acc = tx_valid && m_rdy;
    end
    tx_valid = 1'b0;
  endtask

  int base_p;
  int bad_base;
  int idle_bad;
  int cnt_rxv;
  int ok;

  initial begin
    reset = 1'b1; sel = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0;
    slv_mode = 1'b0; slv_pat = '0; fall_base = 0;
    nbytes = 1; pause_lo = 0; pause_until = 0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cs",    32'(cs0),    32'h1);
    chk("rst_sclk",  32'(sclk0),  32'h0);
    chk("rst_mosi",  32'(mosi0),  32'h0);
    chk("rst_ready", 32'(rdy0),   32'h1);
    chk("rst_rxv",   32'(rxv0),   32'h0);
    chk("rst_rxd",   32'(rxd0),   32'h0);
    chk("rst_busy",  32'(busy0),  32'h0);
    reset = 1'b0;
    bad_base = s_bad;

    // Idle for 10 cycles
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cs0 !== 1'b1 || sclk0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0 || rxv0 !== 1'b0)
        idle_bad++;
    end
    chk("idle_hold", 32'(idle_bad), 32'h0);

    // Single byte 0xA5, loopback
    bytes[0] = 8'hA5; nbytes = 1; base_p = s_pulses;
    run_burst(40);
    chk("a5_pulses",  32'(s_pulses - base_p), 32'd8);
    chk("a5_slave",   32'(s_rx[7:0]),         32'hA5);
    chk("a5_nrxv",    32'(n_rxv),             32'd1);
    chk("a5_rxv_t",   32'(rxv_t[0]),          32'd32);
    chk("a5_rxd",     32'(rxv_d[0]),          32'hA5);
    chk("a5_cs_t",    32'(cs_rise_t),         32'd34);
    chk("a5_rdy_t",   32'(rdy_t),             32'd36);
    chk("a5_busy",    32'(m_busy),            32'h0);

    // Burst 01 02 03, last on 03
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; nbytes = 3;
    base_p = s_pulses;
    run_burst(110);
    chk("b3_nacc",    32'(n_acc),             32'd3);
    chk("b3_acc1",    32'(acc_t[1]),          32'd33);
    chk("b3_acc2",    32'(acc_t[2]),          32'd66);
    chk("b3_pulses",  32'(s_pulses - base_p), 32'd24);
    chk("b3_slave",   32'(s_rx[23:0]),        32'h010203);
    chk("b3_nrxv",    32'(n_rxv),             32'd3);
    chk("b3_rxv0",    32'(rxv_t[0]),          32'd32);
    chk("b3_rxv1",    32'(rxv_t[1]),          32'd65);
    chk("b3_rxv2",    32'(rxv_t[2]),          32'd98);
    chk("b3_rxd",     {8'h0, rxv_d[0], rxv_d[1], rxv_d[2]}, 32'h010203);
    chk("b3_csrises", 32'(cs_rise_n),         32'd1);
    chk("b3_cs_t",    32'(cs_rise_t),         32'd100);
    chk("b3_rdy_t",   32'(rdy_t),             32'd102);

    // Burst with a pause after the first byte
    bytes[0] = 8'h11; bytes[1] = 8'h22; nbytes = 2;
    pause_lo = 32; pause_until = 52;
    run_burst(100);
    pause_lo = 0; pause_until = 0;
    chk("pz_quiet",   32'(pause_bad),         32'd0);
    chk("pz_acc1",    32'(acc_t[1]),          32'd53);
    chk("pz_nrxv",    32'(n_rxv),             32'd2);
    chk("pz_rxv1",    32'(rxv_t[1]),          32'd85);
    chk("pz_rxd",     {16'h0, rxv_d[0], rxv_d[1]}, 32'h1122);
    chk("pz_csrises", 32'(cs_rise_n),         32'd1);
    chk("pz_cs_t",    32'(cs_rise_t),         32'd87);

    // Slave drives 0x3C while master sends 0xFF
    slv_pat = 8'h3C; fall_base = s_falls; slv_mode = 1'b1;
    bytes[0] = 8'hFF; nbytes = 1;
    run_burst(40);
    slv_mode = 1'b0;
    chk("miso_rxd",   32'(rxv_d[0]),          32'h3C);
    chk("miso_slave", 32'(s_rx[7:0]),         32'hFF);

    // Reset after the third rising sclk edge
    tx_data = 8'h5A; tx_last = 1'b1; tx_valid = 1'b1;
    base_p = s_pulses; ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (s_pulses - base_p >= 3) begin
        ok = 1;
        break;
      end
    end
    chk("mid_wait", 32'(ok), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_cs",    32'(cs0),   32'h1);
    chk("mid_sclk",  32'(sclk0), 32'h0);
    chk("mid_rxv",   32'(rxv0),  32'h0);
    chk("mid_ready", 32'(rdy0),  32'h1);
    chk("mid_busy",  32'(busy0), 32'h0);
    reset = 1'b0;
    base_p = s_pulses; cnt_rxv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rxv0) cnt_rxv++;
    end
    chk("mid_norxv",  32'(cnt_rxv),             32'd0);
    chk("mid_nosclk", 32'(s_pulses - base_p),   32'd0);

    // Fresh byte on the CLK_DIV=1 instance
    sel = 1'b1;
    bytes[0] = 8'h96; nbytes = 1; base_p = s_pulses;
    run_burst(24);
    chk("d1_pulses",  32'(s_pulses - base_p), 32'd8);
    chk("d1_rxv_t",   32'(rxv_t[0]),          32'd16);
    chk("d1_rxd",     32'(rxv_d[0]),          32'h96);
    chk("d1_cs_t",    32'(cs_rise_t),         32'd17);
    chk("d1_rdy_t",   32'(rdy_t),             32'd18);
    sel = 1'b0;

    chk("sclk_cs_hi", 32'(s_bad - bad_base),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
